flash_access_sequencer: RTL and testbench
=========================================

FLASH_ACCESS_SEQUENCER -- requirements
Module: flash_access_sequencer

Interface
REQ-001 Parameters SHALL be: RD_WAIT, 2, readEnable cycles per read (1..15); WR_WAIT, 3, writeEnable cycles per write (1..15).
REQ-002 Clock and reset SHALL be: clk input 1 system clock, all state on rising edge; reset input 1 asynchronous active-low reset.
REQ-003 Command ports SHALL be: cmd_valid input 1 request; cmd_op input 2 00 read/01 program/10 row-erase/11 reserved; cmd_addr input 16 {bank[15:12],block[11:8],row[7:0]}; cmd_data input 8 program data; cmd_ready output 1 accept.
REQ-004 Status ports SHALL be: busy output 1 operation in progress; done output 1 one-cycle completion pulse; rd_valid output 1 read-data pulse; rd_data output 8 read result; err output 1 one-cycle error pulse.
REQ-005 Memory ports SHALL be: addr_out output 16 to address register; addr_en output 1 address latch enable; readEnable output 1; writeEnable output 1; mem_wdata output 8 write data; mem_rdata input 8 read data.

Function
REQ-006 Handshake SHALL be cmd_valid&&cmd_ready at a rising edge (cycle T); cmd_ready SHALL be 1 only in IDLE; cmd_op/cmd_addr/cmd_data SHALL be latched at T; cmd_valid outside IDLE SHALL be ignored.
REQ-007 States SHALL be IDLE, ADDR, READ, TURN, WRITE, ERASE, DONE; busy SHALL be 1 in every state except IDLE.
REQ-008 ADDR (cycle T+1) SHALL drive addr_out=latched address and addr_en=1 for one cycle; addr_out SHALL hold until next accept.
REQ-009 Read (op 00): READ SHALL assert readEnable for RD_WAIT cycles; mem_rdata SHALL be captured on the last READ cycle; DONE SHALL pulse done and rd_valid with rd_data=captured value; IDLE follows.
REQ-010 Program (op 01): READ as REQ-009 capturing old; TURN one cycle with both enables 0; WRITE asserts writeEnable for WR_WAIT cycles with mem_wdata=old&cmd_data; DONE pulses done, rd_valid=0.
REQ-011 Program with (old&cmd_data)!=cmd_data (0->1 bit request) SHALL still write old&cmd_data and SHALL pulse err in DONE.
REQ-012 Erase (op 10): ERASE SHALL iterate an 8-bit row counter 0..255, per row asserting writeEnable for WR_WAIT consecutive cycles with mem_wdata=8'hFF, addr_out={latched[15:8],row}, addr_en=1 on the first cycle of each row; latched row bits ignored; DONE follows row 255.
REQ-013 Row counter SHALL terminate at 255 without wrapping; WR_WAIT counter SHALL reload per row.
REQ-014 Reserved op 11 SHALL go ADDR->DONE with no readEnable/writeEnable and SHALL pulse err with done.
REQ-015 readEnable and writeEnable SHALL never be 1 together; at least one cycle with both 0 SHALL separate any read and write.
REQ-016 Latency with defaults: read done at T+4; program done at T+8; erase done at T+2+256*WR_WAIT=T+770; next accept earliest one cycle after done.
REQ-017 mem_wdata SHALL be 0 whenever writeEnable is 0.

Reset
REQ-018 reset low SHALL immediately force IDLE and outputs cmd_ready=1 (while reset high) else 0 during reset, busy=0, done=0, rd_valid=0, err=0, rd_data=0, addr_out=0, addr_en=0, readEnable=0, writeEnable=0, mem_wdata=0, counters=0.
REQ-019 Reset mid-operation SHALL abort without completion pulse; first accept possible on first rising edge after reset release.

Verification
REQ-020 Read: cmd_op=00, cmd_addr=16'h3A5C, mem_rdata=8'h96 -> addr_en at T+1 with addr_out=16'h3A5C, readEnable T+2..T+3, done&rd_valid at T+4, rd_data=8'h96, err=0.
REQ-021 Program legal: old=8'hF0, cmd_data=8'h30 -> writeEnable T+5..T+7, mem_wdata=8'h30, done at T+8, err=0; illegal: old=8'h0F, cmd_data=8'hF1 -> mem_wdata=8'h01, err=1 at T+8.
REQ-022 Erase cmd_addr=16'h52C7 -> 256 rows, addr_out 16'h5200..16'h52FF ascending, 768 writeEnable cycles all mem_wdata=8'hFF, done at T+770, no readEnable.
REQ-023 Reserved op 11 -> done&err at T+2, zero enable activity; cmd_valid held during busy -> no second accept until IDLE.
REQ-024 reset low during erase row 40 -> all enables 0 immediately, no done; new read after release completes normally at T+4.
REQ-025 Every scenario: assertion readEnable&writeEnable never 1, and read/write separated by >=1 idle cycle.

Source files
------------

// File: rtl/flash_access_sequencer.sv
// rtl/flash_access_sequencer.sv - sequences read, program and row-erase accesses to a flash array
module flash_access_sequencer #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        err,
    output logic [15:0] addr_out,
    output logic        addr_en,
    output logic        readEnable,
    output logic        writeEnable,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {IDLE, ADDR, READ, TURN, WRITE, ERASE, DONE} stateType;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [3:0] RD_LAST  = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST  = 4'(WR_WAIT - 1);

    stateType    state, nextState;
    logic [1:0]  opLat;
    logic [7:0]  dataLat;
    logic [7:0]  oldData;
    logic [15:0] addrReg;
    logic [3:0]  waitCnt;
    logic [7:0]  rowCnt;
    logic        accept;
    logic        waitLast;
    logic        rowLast;
    logic        progFault;

    assign cmd_ready = reset && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign waitLast  = (state == READ) ? (waitCnt == RD_LAST) : (waitCnt == WR_LAST);
    assign rowLast   = (rowCnt == 8'hFF);
    // A program can only clear bits; any 0->1 request is flagged but the AND is still written.
    assign progFault = ((oldData & dataLat) != dataLat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (accept) nextState = ADDR;
            ADDR: begin
                case (opLat)
                    OP_READ, OP_PROG: nextState = READ;
                    OP_ERASE:         nextState = ERASE;
                    default:          nextState = DONE;
                endcase
            end
            READ:  if (waitLast) nextState = (opLat == OP_PROG) ? TURN : DONE;
            TURN:  nextState = WRITE;
            WRITE: if (waitLast) nextState = DONE;
            ERASE: if (waitLast && rowLast) nextState = DONE;
            DONE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opLat   <= 2'b00;
            dataLat <= 8'h00;
            oldData <= 8'h00;
            addrReg <= 16'h0000;
            waitCnt <= 4'd0;
            rowCnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    waitCnt <= 4'd0;
                    if (accept) begin
                        opLat   <= cmd_op;
                        dataLat <= cmd_data;
                        addrReg <= cmd_addr;
                    end
                end
                ADDR: begin
                    waitCnt <= 4'd0;
                    rowCnt  <= 8'd0;
                    if (opLat == OP_ERASE) addrReg <= {addrReg[15:8], 8'h00};
                end
                READ: begin
                    if (waitLast) begin
                        oldData <= mem_rdata;
                        waitCnt <= 4'd0;
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                WRITE: waitCnt <= waitLast ? 4'd0 : waitCnt + 4'd1;
                ERASE: begin
                    if (waitLast) begin
                        waitCnt <= 4'd0;
                        // Row 255 is terminal: the counter stops there rather than wrapping.
                        if (!rowLast) begin
                            rowCnt          <= rowCnt + 8'd1;
                            addrReg[7:0]    <= rowCnt + 8'd1;
                        end
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                default: waitCnt <= 4'd0;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign rd_valid    = done && (opLat == OP_READ);
    assign rd_data     = oldData;
    assign err         = done && ((opLat == OP_RSVD) || ((opLat == OP_PROG) && progFault));
    assign addr_out    = addrReg;
    assign addr_en     = (state == ADDR) || ((state == ERASE) && (waitCnt == 4'd0));
    assign readEnable  = (state == READ);
    assign writeEnable = (state == WRITE) || (state == ERASE);
    assign mem_wdata   = (state == WRITE) ? (oldData & dataLat) :
                         (state == ERASE) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_flash_access_sequencer.sv
// tb/tb_flash_access_sequencer.sv - scoreboard bench for flash_access_sequencer
module tb_flash_access_sequencer;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        err;
    logic [15:0] addr_out;
    logic        addr_en;
    logic        readEnable;
    logic        writeEnable;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    flash_access_sequencer #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .busy(busy), .done(done), .rd_valid(rd_valid),
        .rd_data(rd_data), .err(err), .addr_out(addr_out), .addr_en(addr_en),
        .readEnable(readEnable), .writeEnable(writeEnable),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [7:0]  rdData;
        logic [7:0]  wdata;
        logic        err;
        int          lat;
        int          reCnt;
        int          weCnt;
    } expType;

    expType q[$];
    expType cur;
    expType popped;
    int     nChecks = 0;
    int     nErrors = 0;
    int     cyc = 0;
    bit     active = 1'b0;
    int     acceptCyc = 0;
    int     reSeen = 0;
    int     weSeen = 0;
    int     rowSeen = 0;
    logic   prevRe = 1'b0;
    logic   prevWe = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            active = 1'b0;
            prevRe = 1'b0;
            prevWe = 1'b0;
            checkEq("rst_quiet", 32'({done, err, readEnable, writeEnable, addr_en}), 32'd0);
        end else begin
            checkEq("re_we_overlap", 32'(readEnable & writeEnable), 32'd0);
            checkEq("rw_gap", 32'((readEnable && prevWe) || (writeEnable && prevRe)), 32'd0);
            checkEq("ready_busy", 32'(cmd_ready), 32'(!busy));
            if (!writeEnable) checkEq("wdata_idle", 32'(mem_wdata), 32'd0);
            prevRe = readEnable;
            prevWe = writeEnable;
            if (active) begin
                if (readEnable) reSeen++;
                if (writeEnable) begin
                    weSeen++;
                    checkEq("wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
                if (addr_en) begin
                    if (cyc - acceptCyc == 1) begin
                        checkEq("addr_first", 32'(addr_out), 32'(cur.addr));
                    end else begin
                        checkEq("erase_row_addr", 32'(addr_out), 32'({cur.addr[15:8], 8'(rowSeen)}));
                        checkEq("erase_row_time", cyc - acceptCyc, 2 + rowSeen * WR_WAIT);
                        rowSeen++;
                    end
                end
                if (done) begin
                    popped = q.pop_front();
                    checkEq("latency", cyc - acceptCyc, popped.lat);
                    checkEq("err", 32'(err), 32'(popped.err));
                    checkEq("rd_valid", 32'(rd_valid), 32'(popped.op == 2'b00));
                    if (popped.op == 2'b00) checkEq("rd_data", 32'(rd_data), 32'(popped.rdData));
                    checkEq("re_cycles", reSeen, popped.reCnt);
                    checkEq("we_cycles", weSeen, popped.weCnt);
                    checkEq("erase_rows", rowSeen, (popped.op == 2'b10) ? 256 : 0);
                    active = 1'b0;
                end
            end else if (done) begin
                checkEq("stray_done", 32'd1, 32'd0);
            end
            if (cmd_valid && cmd_ready) begin
                if (active || q.size() == 0) begin
                    checkEq("stray_accept", 32'd1, 32'd0);
                end else begin
                    active    = 1'b1;
                    cur       = q[0];
                    acceptCyc = cyc;
                    reSeen    = 0;
                    weSeen    = 0;
                    rowSeen   = 0;
                end
            end
        end
    end

    function automatic expType makeExp(input logic [1:0] op, input logic [15:0] addr,
                                       input logic [7:0] data, input logic [7:0] old);
        expType e;
        e.op = op; e.addr = addr; e.rdData = old; e.wdata = 8'hFF; e.err = 1'b0;
        e.lat = 2; e.reCnt = 0; e.weCnt = 0;
        case (op)
            2'b00: begin e.lat = 2 + RD_WAIT; e.reCnt = RD_WAIT; end
            2'b01: begin
                e.lat = 3 + RD_WAIT + WR_WAIT; e.reCnt = RD_WAIT; e.weCnt = WR_WAIT;
                e.wdata = old & data; e.err = ((old & data) != data);
            end
            2'b10: begin e.lat = 2 + 256 * WR_WAIT; e.weCnt = 256 * WR_WAIT; end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [15:0] addr,
                         input logic [7:0] data, input logic [7:0] old);
        int n;
        q.push_back(makeExp(op, addr, data, old));
        @(posedge clk); #1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; mem_rdata = old;
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] addr,
                         input logic [7:0] data, input logic [7:0] old, input bit hold);
        int n;
        drive(op, addr, data, old);
        if (!hold) cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 2000);
        if (!done) checkEq("done_timeout", 32'd1, 32'd0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        #12;
        checkEq("rst_ready", 32'(cmd_ready), 32'd0);
        checkEq("rst_outs", 32'({busy, done, rd_valid, err, addr_en, readEnable, writeEnable}), 32'd0);
        checkEq("rst_data", 32'({rd_data, mem_wdata, addr_out}), 32'd0);
        @(negedge clk); reset = 1'b1; #1;
        checkEq("ready_after_rst", 32'(cmd_ready), 32'd1);

        issue(2'b00, 16'h3A5C, 8'h00, 8'h96, 1'b0);
        issue(2'b01, 16'h1234, 8'h30, 8'hF0, 1'b0);
        issue(2'b01, 16'h4321, 8'hF1, 8'h0F, 1'b0);
        issue(2'b11, 16'h0BAD, 8'h55, 8'hAA, 1'b0);
        issue(2'b00, 16'h1111, 8'h00, 8'h5A, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'b10) rop = 2'b01;
            issue(rop, 16'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end
        issue(2'b10, 16'h52C7, 8'h00, 8'h00, 1'b0);

        drive(2'b10, 16'h7E19, 8'h00, 8'h00);
        cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(addr_en && writeEnable && addr_out[7:0] == 8'd40) && n < 2000);
        checkEq("row40_reached", 32'(addr_out), 32'h7E28);
        #2 reset = 1'b0;
        #1;
        checkEq("abort_enables", 32'({readEnable, writeEnable, addr_en}), 32'd0);
        checkEq("abort_status", 32'({busy, done, err, cmd_ready}), 32'd0);
        checkEq("abort_regs", 32'({addr_out, mem_wdata}), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; #1;
        checkEq("ready_release", 32'(cmd_ready), 32'd1);
        issue(2'b00, 16'hABCD, 8'h00, 8'h3C, 1'b0);

        repeat (3) @(negedge clk);
        checkEq("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
